// File: rtl/pc_sequencer.sv
// Instruction-cycle sequencer for the basic computer: SC timing states,
// R/IEN/S flip-flops and per-cycle PC/AR/IR/TR/memory strobes.
module pc_sequencer #(
    parameter int SC_W = 4,
    parameter int AW   = 12
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            START,
    input  logic [15:0]     IR,
    input  logic            AC_NEG,
    input  logic            AC_ZERO,
    input  logic            E_ZERO,
    input  logic            DR_ZERO,
    input  logic            FGI,
    input  logic            FGO,
    output logic            PC_INR,
    output logic            PC_LD,
    output logic            PC_CLR,
    output logic            AR_LD_PC,
    output logic            AR_LD_IR,
    output logic            AR_INR,
    output logic            AR_CLR,
    output logic            IR_LD,
    output logic            TR_LD_PC,
    output logic            MEM_WR_PC,
    output logic            MEM_WR_TR,
    output logic [SC_W-1:0] SC,
    output logic            R,
    output logic            IEN,
    output logic            S
);

    logic [SC_W-1:0] sc;
    logic            r, ien, s;
    logic            ind;
    logic [2:0]      opcode;
    logic [AW-1:0]   b;
    logic            sc_clr, hlt, ion, iof, int_done;
    logic            unused_ir;

    assign ind       = IR[15];
    assign opcode    = IR[14:12];
    assign b         = IR[AW-1:0];
    assign unused_ir = ^{b[11:10], b[5]};

    // Execute phases (SC>=3) decode regardless of R so an instruction
    // that raised the interrupt request still completes.
    always_comb begin
        PC_INR    = 1'b0;
        PC_LD     = 1'b0;
        PC_CLR    = 1'b0;
        AR_LD_PC  = 1'b0;
        AR_LD_IR  = 1'b0;
        AR_INR    = 1'b0;
        AR_CLR    = 1'b0;
        IR_LD     = 1'b0;
        TR_LD_PC  = 1'b0;
        MEM_WR_PC = 1'b0;
        MEM_WR_TR = 1'b0;
        sc_clr    = 1'b0;
        hlt       = 1'b0;
        ion       = 1'b0;
        iof       = 1'b0;
        int_done  = 1'b0;
        if (s && CLR) begin
            if (sc < SC_W'(3)) begin
                if (r) begin
                    if (sc == SC_W'(0)) begin
                        AR_CLR   = 1'b1;
                        TR_LD_PC = 1'b1;
                    end else if (sc == SC_W'(1)) begin
                        MEM_WR_TR = 1'b1;
                        PC_CLR    = 1'b1;
                    end else begin
                        PC_INR   = 1'b1;
                        sc_clr   = 1'b1;
                        int_done = 1'b1;
                    end
                end else begin
                    if (sc == SC_W'(0)) begin
                        AR_LD_PC = 1'b1;
                    end else if (sc == SC_W'(1)) begin
                        IR_LD  = 1'b1;
                        PC_INR = 1'b1;
                    end else begin
                        AR_LD_IR = 1'b1;
                    end
                end
            end else if (opcode != 3'd7) begin
                unique case (opcode)
                    3'd0, 3'd1, 3'd2: sc_clr = (sc == SC_W'(5));
                    3'd3: sc_clr = (sc == SC_W'(4));
                    3'd4: begin
                        PC_LD  = (sc == SC_W'(4));
                        sc_clr = (sc == SC_W'(4));
                    end
                    3'd5: begin
                        MEM_WR_PC = (sc == SC_W'(4));
                        AR_INR    = (sc == SC_W'(4));
                        PC_LD     = (sc == SC_W'(5));
                        sc_clr    = (sc == SC_W'(5));
                    end
                    3'd6: begin
                        PC_INR = (sc == SC_W'(6)) && DR_ZERO;
                        sc_clr = (sc == SC_W'(6));
                    end
                    default: ;
                endcase
            end else if (sc == SC_W'(3)) begin
                sc_clr = 1'b1;
                if (!ind) begin
                    PC_INR = (b[4] && !AC_NEG) || (b[3] && AC_NEG)
                          || (b[2] && AC_ZERO) || (b[1] && E_ZERO);
                    hlt    = b[0];
                end else begin
                    PC_INR = (b[9] && FGI) || (b[8] && FGO);
                    ion    = b[7];
                    iof    = b[6];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sc  <= '0;
            r   <= 1'b0;
            ien <= 1'b0;
            s   <= 1'b0;
        end else if (!s) begin
            sc <= '0;
            if (START) s <= 1'b1;
        end else begin
            if (int_done) begin
                ien <= 1'b0;
                r   <= 1'b0;
            end else begin
                // Pre-edge IEN: ION only arms the following instruction.
                if (!r && sc > SC_W'(2) && ien && (FGI || FGO)) r <= 1'b1;
                if (iof) ien <= 1'b0;
                else if (ion) ien <= 1'b1;
            end
            if (hlt) s <= 1'b0;
            sc <= sc_clr ? '0 : sc + SC_W'(1);
        end
    end

    assign SC  = sc;
    assign R   = r;
    assign IEN = ien;
    assign S   = s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        CLK, CLR, START;
    logic [15:0] IR;
    logic        AC_NEG, AC_ZERO, E_ZERO, DR_ZERO, FGI, FGO;
    logic        PC_INR, PC_LD, PC_CLR, AR_LD_PC, AR_LD_IR, AR_INR;
    logic        AR_CLR, IR_LD, TR_LD_PC, MEM_WR_PC, MEM_WR_TR;
    logic [3:0]  SC;
    logic        R, IEN, S;
    logic [10:0] strb;

    int errors = 0;
    int checks = 0;

    localparam logic [10:0] PCI = 11'h400, PCL = 11'h200, PCC = 11'h100;
    localparam logic [10:0] ALP = 11'h080, ALI = 11'h040, AIN = 11'h020;
    localparam logic [10:0] ACL = 11'h010, IRL = 11'h008, TRL = 11'h004;
    localparam logic [10:0] MWP = 11'h002, MWT = 11'h001, NON = 11'h000;

    pc_sequencer dut (
        .CLK(CLK), .CLR(CLR), .START(START), .IR(IR),
        .AC_NEG(AC_NEG), .AC_ZERO(AC_ZERO), .E_ZERO(E_ZERO),
        .DR_ZERO(DR_ZERO), .FGI(FGI), .FGO(FGO),
        .PC_INR(PC_INR), .PC_LD(PC_LD), .PC_CLR(PC_CLR),
        .AR_LD_PC(AR_LD_PC), .AR_LD_IR(AR_LD_IR), .AR_INR(AR_INR),
        .AR_CLR(AR_CLR), .IR_LD(IR_LD), .TR_LD_PC(TR_LD_PC),
        .MEM_WR_PC(MEM_WR_PC), .MEM_WR_TR(MEM_WR_TR),
        .SC(SC), .R(R), .IEN(IEN), .S(S)
    );

    assign strb = {PC_INR, PC_LD, PC_CLR, AR_LD_PC, AR_LD_IR, AR_INR,
                   AR_CLR, IR_LD, TR_LD_PC, MEM_WR_PC, MEM_WR_TR};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // PC operations must be mutually exclusive every cycle
    always @(negedge CLK) begin
        checks++;
        if ($countones({PC_INR, PC_LD, PC_CLR}) > 1) begin
            errors++;
            $display("FAIL pc_excl: got inr/ld/clr=%b%b%b want at most one",
                     PC_INR, PC_LD, PC_CLR);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b0; START = 1'b0; IR = 16'h0;
        AC_NEG = 0; AC_ZERO = 0; E_ZERO = 0; DR_ZERO = 0; FGI = 0; FGO = 0;
        step(); step();
        checks++;
        if ({SC, R, IEN, S} !== 7'b0 || strb !== NON) begin
            errors++;
            $display("FAIL reset: sc=%0d r=%b ien=%b s=%b strb=%h want all 0",
                     SC, R, IEN, S, strb);
        end
        CLR = 1'b1;
        step(); step();
        checks++;
        if (S !== 1'b0 || SC !== 4'd0 || strb !== NON) begin
            errors++;
            $display("FAIL idle: s=%b sc=%0d strb=%h want 0 0 0", S, SC, strb);
        end
    endtask

    task automatic test_bun();
        logic [10:0] e [5];
        e = '{ALP, IRL | PCI, ALI, NON, PCL};
        IR = 16'h4123;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (SC !== 4'(t) || strb !== e[t]) begin
                errors++;
                $display("FAIL bun T%0d: sc=%0d strb=%h want sc=%0d strb=%h",
                         t, SC, strb, t, e[t]);
            end
            step();
        end
        checks++;
        if (SC !== 4'd0 || S !== 1'b1) begin
            errors++;
            $display("FAIL bun_end: sc=%0d s=%b want 0 1", SC, S);
        end
    endtask

    task automatic test_bsa();
        logic [10:0] e [6];
        e = '{ALP, IRL | PCI, ALI, NON, MWP | AIN, PCL};
        IR = 16'h5050;
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (SC !== 4'(t) || strb !== e[t]) begin
                errors++;
                $display("FAIL bsa T%0d: sc=%0d strb=%h want sc=%0d strb=%h",
                         t, SC, strb, t, e[t]);
            end
            step();
        end
        checks++;
        if (SC !== 4'd0) begin
            errors++;
            $display("FAIL bsa_end: sc=%0d want 0", SC);
        end
    endtask

    task automatic test_skip();
        logic [10:0] e [4];
        logic [10:0] z [7];
        for (int k = 0; k < 2; k++) begin
            e = '{ALP, IRL | PCI, ALI, (k == 0) ? PCI : NON};
            IR = 16'h7004;
            AC_ZERO = (k == 0);
            for (int t = 0; t < 4; t++) begin
                checks++;
                if (SC !== 4'(t) || strb !== e[t]) begin
                    errors++;
                    $display("FAIL sza%0d T%0d: sc=%0d strb=%h want sc=%0d strb=%h",
                             k, t, SC, strb, t, e[t]);
                end
                step();
            end
            checks++;
            if (SC !== 4'd0) begin
                errors++;
                $display("FAIL sza%0d_end: sc=%0d want 0", k, SC);
            end
        end
        AC_ZERO = 1'b0;
        z = '{ALP, IRL | PCI, ALI, NON, NON, NON, PCI};
        IR = 16'h6010;
        DR_ZERO = 1'b1;
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (SC !== 4'(t) || strb !== z[t]) begin
                errors++;
                $display("FAIL isz T%0d: sc=%0d strb=%h want sc=%0d strb=%h",
                         t, SC, strb, t, z[t]);
            end
            step();
        end
        DR_ZERO = 1'b0;
        checks++;
        if (SC !== 4'd0) begin
            errors++;
            $display("FAIL isz_end: sc=%0d want 0", SC);
        end
    endtask

    task automatic test_interrupt();
        logic [10:0] e [4];
        logic [10:0] q [3];
        e = '{ALP, IRL | PCI, ALI, NON};
        q = '{ACL | TRL, MWT | PCC, PCI};
        for (int k = 0; k < 2; k++) begin
            IR  = (k == 0) ? 16'hF080 : 16'h7020;
            FGI = (k == 1);
            for (int t = 0; t < 4; t++) begin
                checks++;
                if (SC !== 4'(t) || strb !== e[t]) begin
                    errors++;
                    $display("FAIL int%0d T%0d: sc=%0d strb=%h want sc=%0d strb=%h",
                             k, t, SC, strb, t, e[t]);
                end
                step();
            end
            checks++;
            if (IEN !== 1'b1 || R !== 1'(k) || SC !== 4'd0) begin
                errors++;
                $display("FAIL int%0d_end: ien=%b r=%b sc=%0d want 1 %0d 0",
                         k, IEN, R, SC, k);
            end
        end
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (SC !== 4'(t) || R !== 1'b1 || strb !== q[t]) begin
                errors++;
                $display("FAIL rt%0d: sc=%0d r=%b strb=%h want sc=%0d r=1 strb=%h",
                         t, SC, R, strb, t, q[t]);
            end
            step();
        end
        FGI = 1'b0;
        checks++;
        if (IEN !== 1'b0 || R !== 1'b0 || SC !== 4'd0) begin
            errors++;
            $display("FAIL rt_end: ien=%b r=%b sc=%0d want 0 0 0", IEN, R, SC);
        end
    endtask

    task automatic test_halt();
        logic [10:0] e [4];
        e = '{ALP, IRL | PCI, ALI, NON};
        IR = 16'h7001;
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (SC !== 4'(t) || S !== 1'b1 || strb !== e[t]) begin
                errors++;
                $display("FAIL hlt T%0d: sc=%0d s=%b strb=%h want sc=%0d s=1 strb=%h",
                         t, SC, S, strb, t, e[t]);
            end
            if (t == 1) START = 1'b1;
            if (t == 2) START = 1'b0;
            step();
        end
        checks++;
        if (S !== 1'b0 || SC !== 4'd0 || R !== 1'b0 || strb !== NON) begin
            errors++;
            $display("FAIL hlt_end: s=%b sc=%0d r=%b strb=%h want 0 0 0 0",
                     S, SC, R, strb);
        end
        step(); step();
        checks++;
        if (S !== 1'b0 || SC !== 4'd0 || strb !== NON) begin
            errors++;
            $display("FAIL hlt_hold: s=%b sc=%0d strb=%h want 0 0 0", S, SC, strb);
        end
        START = 1'b1;
        step();
        START = 1'b0;
        checks++;
        if (S !== 1'b1 || SC !== 4'd0 || strb !== ALP) begin
            errors++;
            $display("FAIL restart: s=%b sc=%0d strb=%h want 1 0 %h",
                     S, SC, strb, ALP);
        end
    endtask

    task automatic test_clr_mid();
        IR = 16'hF080;
        for (int t = 0; t < 4; t++) step();
        checks++;
        if (IEN !== 1'b1 || SC !== 4'd0) begin
            errors++;
            $display("FAIL ion_pre: ien=%b sc=%0d want 1 0", IEN, SC);
        end
        IR = 16'h5050;
        for (int t = 0; t < 4; t++) step();
        checks++;
        if (SC !== 4'd4 || strb !== (MWP | AIN)) begin
            errors++;
            $display("FAIL clr_pre: sc=%0d strb=%h want 4 %h", SC, strb, MWP | AIN);
        end
        #2;
        CLR = 1'b0;
        #1;
        checks++;
        if ({SC, R, IEN, S} !== 7'b0 || strb !== NON) begin
            errors++;
            $display("FAIL clr_mid: sc=%0d r=%b ien=%b s=%b strb=%h want all 0",
                     SC, R, IEN, S, strb);
        end
        step();
        CLR = 1'b1;
        step();
        checks++;
        if ({SC, R, IEN, S} !== 7'b0 || strb !== NON) begin
            errors++;
            $display("FAIL clr_post: sc=%0d r=%b ien=%b s=%b strb=%h want all 0",
                     SC, R, IEN, S, strb);
        end
    endtask

    initial begin
        test_reset();
        test_bun();
        test_bsa();
        test_skip();
        test_interrupt();
        test_halt();
        test_clr_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
